// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg: shared state/owner encodings for the I/D memory arbiter.
// Rev 1.0
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbState_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int STARVE_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_arb_prio.sv
`default_nettype none
// ============================================================================
// mem_arbiter_arb_prio: combinational D-over-I grant with I starvation override.
// Rev 1.0
// ============================================================================
module mem_arbiter_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 2
) (
    input  logic                i_reqI,
    input  logic                i_reqD,
    input  logic [STARVE_W-1:0] i_starveCnt,
    output logic                o_grantI,
    output logic                o_grantD
);

    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_MAX);

    logic w_iStarved;

    assign w_iStarved = i_reqI && (i_starveCnt == c_STARVE_MAX);
    assign o_grantD   = i_reqD && !w_iStarved;
    assign o_grantI   = i_reqI && !o_grantD;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: single-outstanding I/D cache arbiter onto a unified memory port.
// Rev 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 16,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_stall,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0]          c_IDLE       = IDLE;
    localparam logic [1:0]          c_ISSUE      = ISSUE;
    localparam logic [1:0]          c_WAIT       = WAIT;
    localparam logic [1:0]          c_RESP       = RESP;
    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] c_ONE        = STARVE_W'(1);

    logic [1:0]          r_state;
    owner_t              r_owner;
    logic                r_wr;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [DW-1:0]       r_iRdata;
    logic [DW-1:0]       r_dRdata;
    logic [STARVE_W-1:0] r_starveCnt;
    logic                w_grantI;
    logic                w_grantD;
    logic                w_idle;
    logic                w_accept;
    logic                w_capture;

    mem_arbiter_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arbPrio (
        .i_reqI      (i_req),
        .i_reqD      (d_req),
        .i_starveCnt (r_starveCnt),
        .o_grantI    (w_grantI),
        .o_grantD    (w_grantD)
    );

    assign w_idle    = (r_state == c_IDLE);
    assign w_accept  = (r_state == c_ISSUE) && !mem_stall;
    // Completion counts only once the command has actually been taken by memory.
    assign w_capture = mem_done && (w_accept || (r_state == c_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_owner     <= OWN_I;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_starveCnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grantI || w_grantD) begin
                        r_owner <= w_grantD ? OWN_D : OWN_I;
                        r_addr  <= w_grantD ? d_addr : i_addr;
                        r_wr    <= w_grantD && d_wr;
                        r_wdata <= w_grantD ? d_wdata : '0;
                        if (w_grantD && i_req) begin
                            if (r_starveCnt != c_STARVE_MAX) begin
                                r_starveCnt <= r_starveCnt + c_ONE;
                            end
                        end else begin
                            r_starveCnt <= '0;
                        end
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_accept) begin
                        r_state <= mem_done ? c_RESP : c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (mem_done) begin
                        r_state <= c_RESP;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iRdata <= '0;
            r_dRdata <= '0;
        end else if (w_capture) begin
            if (r_owner == OWN_I) begin
                r_iRdata <= mem_rdata;
            end else if (!r_wr) begin
                r_dRdata <= mem_rdata;
            end
        end
    end

    assign i_ack     = rst_n && w_idle && w_grantI;
    assign d_ack     = rst_n && w_idle && w_grantD;
    assign i_done    = (r_state == c_RESP) && (r_owner == OWN_I);
    assign d_done    = (r_state == c_RESP) && (r_owner == OWN_D);
    assign i_rdata   = r_iRdata;
    assign d_rdata   = r_dRdata;
    assign mem_rd    = (r_state == c_ISSUE) && !r_wr;
    assign mem_wr    = (r_state == c_ISSUE) && r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = !w_idle;

endmodule
`default_nettype wire
